goertzel_tone_gen: RTL and testbench
====================================

Name: goertzel_tone_gen

Overview:
Digital-resonator sine generator built on the same second-order recurrence as the Goertzel filter, run in the transmit direction: y[n] = COEFF*y[n-1] - y[n-2] with zero input.
It produces a fixed-frequency, programmable-amplitude, programmable-length burst of 16-bit signed samples on a valid/ready stream.
Its use is to drive the receiver DSP chain (Goertzel bank) for loopback and self-test, and to act as a bench stimulus source.

Parameters:
COEFF, 0, signed 2*cos(w) in Q(COEFF_BITS); sets tone frequency w; must match the receiver's coefficient for that bin.
SIN_COEFF, 16384, signed sin(w) in Q(COEFF_BITS); used once per burst to seed y[1].
COEFF_BITS, 14, fractional bits of COEFF and SIN_COEFF.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start_i  in  1  single-cycle pulse; begins a burst; ignored while busy_o=1
amp_i  in  16  signed peak amplitude; captured on accepted start_i
len_i  in  16  burst length in samples; 0 = continuous until stop; captured on accepted start_i
stop_i  in  1  requests an early end of a running burst
data_o  out  16  signed sample, saturated
valid_o  out  1  data_o/last_o are valid
ready_i  in  1  downstream accepts the beat when valid_o & ready_i
last_o  out  1  marks the final beat of the burst
busy_o  out  1  high in SEED and RUN

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; y_cur, y_prev, count, stop_pend = 0; data_o=0, valid_o=0, last_o=0, busy_o=0.
- Internal state y_cur and y_prev is 32-bit signed. The product is at least 64-bit; scaling is an arithmetic right shift by COEFF_BITS (floor toward -inf). Internal overflow wraps in two's complement.
- Output formatting: data_o = sat16(y_cur), clamped to the range [-32768, 32767]. Only the output is saturated; the internal state is not.
- FSM IDLE: valid_o=0. When start_i=1: capture amp_i and len_i, clear count and stop_pend, go to SEED.
- FSM SEED (1 cycle):
  - y_prev <= 0.
  - y_cur <= 0, which is sample 0.
  - seed <= (amp*SIN_COEFF) >>> COEFF_BITS, the sample-1 value.
  - Go to RUN, with valid_o=1 on the next cycle.
  - last of beat 0 = (len==1) | stop_i.
- FSM RUN: valid_o=1. data_o and last_o are held stable while valid_o & !ready_i (no change mid-stall).
- On each handshake, if last_o=1: go to IDLE and drop valid_o the next cycle.
- On each handshake, otherwise, load the next beat:
  - For beat 0 -> 1: y_prev <= y_cur; y_cur <= seed.
  - For later beats: y_prev <= y_cur; y_cur <= ((y_cur*COEFF) >>> COEFF_BITS) - y_prev.
  - count <= count+1.
  - New last_o = (len!=0 & count+1 == len-1) | stop_pend | stop_i.
- Throughput: 1 sample/cycle while ready_i=1. Latency: start_i at cycle t gives the first valid_o at cycle t+2.
- stop_i: ignored in IDLE. In SEED or RUN it sets stop_pend. It never alters the beat currently presented; the next loaded beat carries last_o=1. stop_i arriving together with a handshake applies to the beat loaded by that handshake.
- len=0: bursts run forever until stop.
- start_i during SEED or RUN: ignored, with no re-capture.
- Reset mid-burst: immediate return to the reset values; no last_o is emitted.
- The burst emits exactly len beats when stop is not used.

Decomposition:
- Shared package dsp_pkg holds:
  - tone_state_t enum {IDLE, SEED, RUN};
  - function mult_coeff(a, b, frac_bits), which is the 64-bit product followed by an arithmetic shift;
  - function sat16.
- The same mult_coeff is reused by the Goertzel filter so both ends quantise identically.
- No sub-module: the recurrence datapath and the FSM fit in one module.

Test Plan:
- w=pi/2 (COEFF=0, SIN_COEFF=16384), amp=1000, len=6, ready_i=1 -> data 0,1000,0,-1000,0,1000; last_o only on beat 6; first valid_o 2 cycles after start_i; busy_o drops after the final handshake.
- w=pi/3 (COEFF=16384, SIN_COEFF=14189), amp=1000, len=7 -> data 0,866,866,0,-866,-866,0.
- Backpressure on the pi/3 tone: hold ready_i=0 for 3 cycles while beat 2 (866) is presented -> data_o=866 and last_o stay stable; the sequence resumes unchanged with no beat lost or duplicated.
- len=0 with the pi/2 tone: run 10 beats, pulse stop_i while beat 10 is presented -> beat 11 has last_o=1; valid_o is 0 after its handshake; total 11 beats.
- Saturation: COEFF=40960 (2.5), SIN_COEFF=16384, amp=20000, len=4 -> data 0,20000,32767,32767, from internal values 0, 20000, 50000, 105000.
- Reset and start collision:
  - rst_n low mid-burst -> all outputs 0 asynchronously.
  - A new burst after release starts again at beat 0.
  - A start_i pulse during RUN is ignored: amp and len are unchanged and the sequence continues.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared DSP definitions for the tone generator and the Goertzel receiver bank.
// Both ends use mult_coeff so their coefficient quantisation is bit-identical.
package dsp_pkg;

    typedef enum logic [1:0] {IDLE, SEED, RUN} tone_state_t;

    // Full 64-bit product, arithmetic shift (floor toward -inf), wrap to 32 bits.
    function automatic logic signed [31:0] mult_coeff(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input int unsigned        frac_bits
    );
        logic signed [63:0] prod;
        prod = 64'(a) * 64'(b);
        return 32'(prod >>> frac_bits);
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
        if (v > 32'sd32767) begin
            return 16'sh7fff;
        end else if (v < -32'sd32768) begin
            return 16'sh8000;
        end else begin
            return v[15:0];
        end
    endfunction

endpackage

// File: rtl/goertzel_tone_gen.sv
// Resonator sine-burst generator: y[n] = COEFF*y[n-1] - y[n-2], seeded with
// y[0]=0 and y[1]=amp*sin(w), streamed out saturated on a valid/ready port.
module goertzel_tone_gen #(
    parameter int          COEFF      = 0,
    parameter int          SIN_COEFF  = 16384,
    parameter int unsigned COEFF_BITS = 14
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [15:0] amp_i,
    input  logic [15:0] len_i,
    input  logic        stop_i,
    output logic [15:0] data_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        last_o,
    output logic        busy_o
);
    import dsp_pkg::*;

    localparam logic signed [31:0] COEFF_Q = 32'(COEFF);
    localparam logic signed [31:0] SIN_Q   = 32'(SIN_COEFF);

    tone_state_t        state_q;
    logic signed [31:0] y_cur_q;
    logic signed [31:0] y_prev_q;
    logic signed [31:0] seed_q;
    logic signed [15:0] amp_q;
    logic [15:0]        len_q;
    logic [15:0]        count_q;
    logic               stop_pend_q;
    logic               valid_q;
    logic               last_q;
    logic               busy_q;

    logic signed [31:0] seed_d;
    logic signed [31:0] y_next_d;
    logic               last_next_d;

    always_comb begin
        seed_d      = mult_coeff({{16{amp_q[15]}}, amp_q}, SIN_Q, COEFF_BITS);
        // Beat 1 comes from the seed; the recurrence only applies from beat 2 on.
        y_next_d    = (count_q == '0) ? seed_q
                                      : mult_coeff(y_cur_q, COEFF_Q, COEFF_BITS) - y_prev_q;
        last_next_d = ((len_q != '0) && (count_q + 16'd1 == len_q - 16'd1))
                      || stop_pend_q || stop_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            y_cur_q     <= '0;
            y_prev_q    <= '0;
            seed_q      <= '0;
            amp_q       <= '0;
            len_q       <= '0;
            count_q     <= '0;
            stop_pend_q <= 1'b0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    if (start_i) begin
                        amp_q       <= amp_i;
                        len_q       <= len_i;
                        count_q     <= '0;
                        stop_pend_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= SEED;
                    end
                end
                SEED: begin
                    y_prev_q    <= '0;
                    y_cur_q     <= '0;
                    seed_q      <= seed_d;
                    stop_pend_q <= stop_pend_q | stop_i;
                    valid_q     <= 1'b1;
                    last_q      <= (len_q == 16'd1) || stop_i;
                    state_q     <= RUN;
                end
                RUN: begin
                    if (stop_i) begin
                        stop_pend_q <= 1'b1;
                    end
                    if (ready_i) begin
                        if (last_q) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            y_prev_q <= y_cur_q;
                            y_cur_q  <= y_next_d;
                            count_q  <= count_q + 16'd1;
                            last_q   <= last_next_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_o  = sat16(y_cur_q);
    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_goertzel_tone_gen.sv
// Scoreboard bench: three generators (pi/2, pi/3, overdriven 2.5) share stimulus;
// expected bursts come from an integer model of the recurrence.
module tb_goertzel_tone_gen;

    localparam int N = 3;
    int C_TBL[N] = '{0, 16384, 40960};
    int S_TBL[N] = '{16384, 14189, 16384};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        ready;
    logic [15:0] amp;
    logic [15:0] len;
    logic [15:0] data  [N];
    logic        valid [N];
    logic        last  [N];
    logic        busy  [N];

    typedef struct {
        int d;
        int l;
    } beat_t;
    beat_t exp_q[N][$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    goertzel_tone_gen #(.COEFF(0), .SIN_COEFF(16384), .COEFF_BITS(14)) u_pi2 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .amp_i(amp), .len_i(len),
        .stop_i(stop), .data_o(data[0]), .valid_o(valid[0]), .ready_i(ready),
        .last_o(last[0]), .busy_o(busy[0]));
    goertzel_tone_gen #(.COEFF(16384), .SIN_COEFF(14189), .COEFF_BITS(14)) u_pi3 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .amp_i(amp), .len_i(len),
        .stop_i(stop), .data_o(data[1]), .valid_o(valid[1]), .ready_i(ready),
        .last_o(last[1]), .busy_o(busy[1]));
    goertzel_tone_gen #(.COEFF(40960), .SIN_COEFF(16384), .COEFF_BITS(14)) u_sat (
        .clk(clk), .rst_n(rst_n), .start_i(start), .amp_i(amp), .len_i(len),
        .stop_i(stop), .data_o(data[2]), .valid_o(valid[2]), .ready_i(ready),
        .last_o(last[2]), .busy_o(busy[2]));

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    // floor(p / 2^14) written as a division with explicit rounding toward -inf
    function automatic longint floor_q14(input longint p);
        longint q;
        q = p / 16384;
        if (p < 0 && (p % 16384) != 0) q = q - 1;
        return q;
    endfunction

    function automatic int sat(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic void push_burst(input int amp_v, input int n);
        for (int i = 0; i < N; i++) begin
            int cur = 0;
            int prv = 0;
            int nxt;
            int seed = int'(floor_q14(longint'(amp_v) * longint'(S_TBL[i])));
            for (int k = 0; k < n; k++) begin
                beat_t b;
                if (k == 1) begin
                    prv = cur;
                    cur = seed;
                end else if (k > 1) begin
                    nxt = int'(floor_q14(longint'(cur) * longint'(C_TBL[i])) - longint'(prv));
                    prv = cur;
                    cur = nxt;
                end
                b.d = sat(cur);
                b.l = (k == n - 1) ? 1 : 0;
                exp_q[i].push_back(b);
            end
        end
    endfunction

    // Monitor: samples between edges; a stalled beat is re-compared until taken.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                for (int i = 0; i < N; i++) begin
                    if (valid[i]) begin
                        if (exp_q[i].size() == 0) begin
                            chk($sformatf("unexpected_beat%0d", i), 1, 0);
                        end else begin
                            chk($sformatf("data%0d", i), int'($signed(data[i])), exp_q[i][0].d);
                            chk($sformatf("last%0d", i), int'(last[i]), exp_q[i][0].l);
                            if (ready) void'(exp_q[i].pop_front());
                        end
                    end
                end
            end
        end
    end

    task automatic burst(input int amp_v, input int len_v, input int stop_at,
                         input int inj_at, input int stall_at, input int rnd_ready);
        int total;
        int hs = 0;
        int cyc = 0;
        int stall_cnt = 0;
        bit stop_done = 0;
        bit inj_done = 0;
        if (len_v == 0) total = stop_at + 2;
        else if (stop_at >= 0 && stop_at + 2 < len_v) total = stop_at + 2;
        else total = len_v;
        @(negedge clk);
        start = 1'b1;
        amp   = 16'(amp_v);
        len   = 16'(len_v);
        ready = 1'b1;
        push_burst(amp_v, total);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            chk("seed_valid", int'(valid[i]), 0);
            chk("seed_busy", int'(busy[i]), 1);
        end
        @(negedge clk);
        for (int i = 0; i < N; i++) chk("first_valid", int'(valid[i]), 1);
        while (hs < total && cyc < 2000) begin
            ready = (rnd_ready != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (stall_at == hs && stall_cnt < 3) begin
                ready = 1'b0;
                stall_cnt++;
            end
            stop = (stop_at == hs && !stop_done);
            if (stop) stop_done = 1;
            if (inj_at == hs && !inj_done) begin
                start    = 1'b1;
                amp      = 16'h1234;
                len      = 16'd2;
                inj_done = 1;
            end else begin
                start = 1'b0;
            end
            if (valid[0] && ready) hs++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        stop  = 1'b0;
        ready = 1'b1;
        chk("burst_in_time", int'(cyc < 2000), 1);
        for (int i = 0; i < N; i++) begin
            chk("end_valid", int'(valid[i]), 0);
            chk("end_busy", int'(busy[i]), 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        ready = 1'b1;
        amp   = '0;
        len   = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk("rst_data", int'(data[i]), 0);
            chk("rst_valid", int'(valid[i]), 0);
            chk("rst_last", int'(last[i]), 0);
            chk("rst_busy", int'(busy[i]), 0);
        end
        rst_n = 1'b1;

        burst(1000, 6, -1, -1, -1, 0);
        burst(1000, 7, -1, -1, 2, 0);
        burst(1000, 0, 9, -1, -1, 0);
        burst(20000, 4, -1, -1, -1, 0);
        burst(1000, 8, -1, 3, -1, 0);
        burst(-700, 1, -1, -1, -1, 0);

        // Asynchronous reset in the middle of a burst
        @(negedge clk);
        start = 1'b1;
        amp   = 16'd3000;
        len   = 16'd20;
        push_burst(3000, 20);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) exp_q[i].delete();
        #1;
        for (int i = 0; i < N; i++) begin
            chk("midrst_data", int'(data[i]), 0);
            chk("midrst_valid", int'(valid[i]), 0);
            chk("midrst_last", int'(last[i]), 0);
            chk("midrst_busy", int'(busy[i]), 0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        burst(1000, 3, -1, -1, -1, 0);

        for (int r = 0; r < 25; r++) begin
            int a_v;
            int l_v;
            int s_at;
            int i_at;
            a_v = int'($signed(16'($urandom_range(0, 65535))));
            l_v = int'($urandom_range(0, 10));
            if (l_v == 0) s_at = int'($urandom_range(0, 8));
            else s_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, l_v)) : -1;
            i_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
            burst(a_v, l_v, s_at, i_at, -1, 1);
        end

        repeat (2) @(negedge clk);
        for (int i = 0; i < N; i++) chk("leftover_beats", exp_q[i].size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
